// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_pkg: state, opcode and datapath-control encodings shared by the NITC-RISC24 controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_RWB, S_MADR, S_MRD,
    S_MWB, S_MWR, S_BEQ, S_JAL, S_HALT, S_FAULT
  } state_e;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_JAL = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;
  localparam logic [1:0] RD_8_6  = 2'b00;
  localparam logic [1:0] RD_5_3  = 2'b01;
  localparam logic [1:0] RD_11_9 = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: datapath/memory signals between the controller (master) and the datapath (slave)
interface mc_ctrl_fsm_if #(parameter int OP_W = 4, parameter int CNT_W = 16);
  logic [OP_W-1:0]  op;
  logic [1:0]       cz;
  logic             alu_zero, alu_carry, mem_ready;
  logic             mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]       alu_src_b, alu_op;
  logic             alu_cin, reg_write;
  logic [1:0]       reg_dst, wb_sel;
  logic             flag_c, flag_z;
  logic [3:0]       state_o;
  logic             halted, fault;
  logic [CNT_W-1:0] retired;
  modport master (
    input  op, cz, alu_zero, alu_carry, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, alu_cin, reg_write, reg_dst, wb_sel, flag_c, flag_z, state_o,
           halted, fault, retired
  );
  modport slave (
    output op, cz, alu_zero, alu_carry, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, alu_cin, reg_write, reg_dst, wb_sel, flag_c, flag_z, state_o,
           halted, fault, retired
  );
endinterface

// File: rtl/mc_ctrl_fsm_mem_wait.sv
// mc_mem_wait: counts consecutive not-ready memory cycles and flags a timeout on the last allowed one
module mc_mem_wait #(parameter int WAIT_W = 4) (
  input  logic clk,
  input  logic reset,
  input  logic in_mem_state,
  input  logic mem_ready,
  output logic timeout
);
  localparam logic [WAIT_W-1:0] LAST = WAIT_W'((1 << WAIT_W) - 2);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic stall;
  assign stall = in_mem_state && !mem_ready;
  assign cnt_d = stall ? cnt_q + 1'b1 : '0;
  // this not-ready cycle would bring the count to 2^WAIT_W-1
  assign timeout = stall && cnt_q == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control unit for NITC-RISC24 with memory handshake, cz flags and retire count
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int WAIT_W = 4,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          reset,
  mc_ctrl_fsm_if.master bus
);
  state_e state_q, state_d;
  logic fc_q, fc_d, fz_q, fz_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [OP_W-1:0] op;
  logic is_add, is_adi, is_ndu, is_lw, is_sw, is_beq, is_jal, is_hlt;
  logic in_mem, timeout, skip, retire;
  assign op     = bus.op;
  assign is_add = op == OP_W'(OP_ADD);
  assign is_adi = op == OP_W'(OP_ADI);
  assign is_ndu = op == OP_W'(OP_NDU);
  assign is_lw  = op == OP_W'(OP_LW);
  assign is_sw  = op == OP_W'(OP_SW);
  assign is_beq = op == OP_W'(OP_BEQ);
  assign is_jal = op == OP_W'(OP_JAL);
  assign is_hlt = op == OP_W'(OP_HLT);
  assign skip = (is_add || is_ndu) &&
                ((bus.cz == 2'b10 && !fc_q) || (bus.cz == 2'b01 && !fz_q));
  assign in_mem = state_q inside {S_FETCH, S_MRD, S_MWR};
  mc_mem_wait #(.WAIT_W(WAIT_W)) u_wait (
    .clk(clk), .reset(reset), .in_mem_state(in_mem), .mem_ready(bus.mem_ready), .timeout(timeout)
  );
  always_comb begin
    state_d       = state_q;
    fc_d          = fc_q;
    fz_d          = fz_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.iord      = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = SRCB_B;
    bus.alu_op    = ALU_ADD;
    bus.alu_cin   = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst   = RD_8_6;
    bus.wb_sel    = WB_ALU;
    bus.halted    = 1'b0;
    bus.fault     = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = SRCB_ONE;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        state_d = bus.mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_BR;
        state_d = skip                        ? S_FETCH :
                  (is_add || is_adi || is_ndu) ? S_EXEC  :
                  (is_lw || is_sw)             ? S_MADR  :
                  is_beq                       ? S_BEQ   :
                  is_jal                       ? S_JAL   :
                  is_hlt                       ? S_HALT  : S_FETCH;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = is_adi ? SRCB_IMM : SRCB_B;
        bus.alu_op    = is_ndu ? ALU_NAND : ALU_ADD;
        bus.alu_cin   = is_add && bus.cz == 2'b11 && fc_q;
        fz_d    = bus.alu_zero;
        fc_d    = is_ndu ? fc_q : bus.alu_carry;
        state_d = S_RWB;
      end
      S_RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = is_adi ? RD_8_6 : RD_5_3;
        state_d = S_FETCH;
      end
      S_MADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_d = is_lw ? S_MRD : S_MWR;
      end
      S_MRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        state_d = bus.mem_ready ? S_MWB : timeout ? S_FAULT : S_MRD;
      end
      S_MWB: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_MDR;
        state_d = S_FETCH;
      end
      S_MWR: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        bus.mem_we  = 1'b1;
        state_d = bus.mem_ready ? S_FETCH : timeout ? S_FAULT : S_MWR;
      end
      S_BEQ: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 1'b1;
        bus.pc_write  = bus.alu_zero;
        state_d = S_FETCH;
      end
      S_JAL: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = WB_PC;
        bus.reg_dst   = RD_11_9;
        bus.pc_write  = 1'b1;
        bus.pc_src    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: bus.fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
  end
  // only completed instructions count; skips and NOPs return to FETCH from DECODE
  assign retire = state_d == S_FETCH && (state_q inside {S_RWB, S_MWB, S_MWR, S_BEQ, S_JAL});
  assign ret_d  = ret_q + CNT_W'(retire);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_START;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      ret_q   <= ret_d;
    end
  assign bus.flag_c  = fc_q;
  assign bus.flag_z  = fz_q;
  assign bus.state_o = state_q;
  assign bus.retired = ret_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: random instruction stream against an instruction-level model of the controller
module tb_mc_ctrl_fsm;
  import mc_pkg::*;
  localparam int WAIT_W = 3;
  localparam int CNT_W  = 3;
  localparam int LIMIT  = (1 << WAIT_W) - 1;
  typedef struct packed {
    logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic alu_cin, reg_write;
    logic [1:0] reg_dst, wb_sel;
  } ctl_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic m_c, m_z;
  int m_ret;
  ctl_t e;
  logic [3:0] ops [16] = '{OP_ADD, OP_ADD, OP_ADI, OP_NDU, OP_NDU, OP_LW, OP_LW, OP_SW,
                           OP_SW, OP_BEQ, OP_BEQ, OP_JAL, 4'b0011, 4'b0111, OP_ADI, OP_HLT};
  mc_ctrl_fsm_if #(.OP_W(4), .CNT_W(CNT_W)) bus ();
  mc_ctrl_fsm #(.OP_W(4), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic noise();
    bus.alu_zero  = 1'($urandom);
    bus.alu_carry = 1'($urandom);
    bus.mem_ready = 1'($urandom);
  endtask
  task automatic observe(input string tag, input state_e st);
    ctl_t g;
    @(negedge clk);
    g = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
         bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.alu_cin, bus.reg_write,
         bus.reg_dst, bus.wb_sel};
    check({tag, ":state"}, 32'(bus.state_o), 32'(st));
    check({tag, ":ctl"}, 32'(g), 32'(e));
    check({tag, ":flags"}, 32'({bus.flag_c, bus.flag_z}), 32'({m_c, m_z}));
    check({tag, ":retired"}, 32'(bus.retired), 32'(m_ret));
    check({tag, ":halt_fault"}, 32'({bus.halted, bus.fault}), 32'({st == S_HALT, st == S_FAULT}));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("async_reset_state", 32'(bus.state_o), 32'(S_START));
    check("async_reset_mem_req", 32'(bus.mem_req), 32'd0);
    m_c = 1'b0;
    m_z = 1'b0;
    m_ret = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    noise();
    e = '0;
    observe("start", S_START);
  endtask
  task automatic mem_phase(input string tag, input state_e st, input int waits, input logic done);
    for (int i = 0; i <= waits; i++) begin
      if (i == waits && !done) break;
      noise();
      bus.mem_ready = (i == waits);
      e = '0;
      e.mem_req   = 1'b1;
      e.iord      = st != S_FETCH;
      e.mem_we    = st == S_MWR;
      e.alu_src_b = (st == S_FETCH) ? 2'd1 : 2'd0;
      e.ir_write  = st == S_FETCH && i == waits;
      e.pc_write  = st == S_FETCH && i == waits;
      observe(tag, st);
    end
  endtask
  task automatic retire_one();
    m_ret = (m_ret + 1) % (1 << CNT_W);
  endtask
  task automatic run_instr(input logic [3:0] op, input logic [1:0] cz, input int w1, input int w2);
    logic az, ac;
    bus.op = op;
    bus.cz = cz;
    mem_phase("fetch", S_FETCH, w1, 1'b1);
    noise();
    e = '0;
    e.alu_src_b = 2'd3;
    observe("decode", S_DECODE);
    if ((op == OP_ADD || op == OP_NDU) && ((cz == 2'b10 && !m_c) || (cz == 2'b01 && !m_z))) return;
    case (op)
      OP_ADD, OP_ADI, OP_NDU: begin
        az = 1'($urandom);
        ac = 1'($urandom);
        noise();
        bus.alu_zero  = az;
        bus.alu_carry = ac;
        e = '0;
        e.alu_src_a = 1'b1;
        e.alu_src_b = (op == OP_ADI) ? 2'd2 : 2'd0;
        e.alu_op    = (op == OP_NDU) ? 2'd2 : 2'd0;
        e.alu_cin   = op == OP_ADD && cz == 2'b11 && m_c;
        observe("exec", S_EXEC);
        m_z = az;
        if (op != OP_NDU) m_c = ac;
        noise();
        e = '0;
        e.reg_write = 1'b1;
        e.reg_dst   = (op == OP_ADI) ? 2'd0 : 2'd1;
        observe("rwb", S_RWB);
        retire_one();
      end
      OP_LW, OP_SW: begin
        noise();
        e = '0;
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'd2;
        observe("madr", S_MADR);
        mem_phase(op == OP_LW ? "mrd" : "mwr", op == OP_LW ? S_MRD : S_MWR, w2, 1'b1);
        if (op == OP_LW) begin
          noise();
          e = '0;
          e.reg_write = 1'b1;
          e.wb_sel    = 2'd1;
          observe("mwb", S_MWB);
        end
        retire_one();
      end
      OP_BEQ: begin
        az = 1'($urandom);
        noise();
        bus.alu_zero = az;
        e = '0;
        e.alu_src_a = 1'b1;
        e.alu_op    = 2'd1;
        e.pc_src    = 1'b1;
        e.pc_write  = az;
        observe("beq", S_BEQ);
        retire_one();
      end
      OP_JAL: begin
        noise();
        e = '0;
        e.reg_write = 1'b1;
        e.wb_sel    = 2'd2;
        e.reg_dst   = 2'd2;
        e.pc_write  = 1'b1;
        e.pc_src    = 1'b1;
        observe("jal", S_JAL);
        retire_one();
      end
      OP_HLT: begin
        e = '0;
        for (int i = 0; i < 3; i++) begin
          noise();
          observe("halt", S_HALT);
        end
        do_reset();
      end
      default: ;
    endcase
  endtask
  task automatic timeout_test(input logic [3:0] op, input state_e st);
    bus.op = op;
    bus.cz = 2'b00;
    if (st != S_FETCH) begin
      mem_phase("fetch", S_FETCH, 0, 1'b1);
      noise();
      e = '0;
      e.alu_src_b = 2'd3;
      observe("decode", S_DECODE);
      noise();
      e = '0;
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'd2;
      observe("madr", S_MADR);
    end
    mem_phase("timeout_wait", st, LIMIT, 1'b0);
    e = '0;
    for (int i = 0; i < 3; i++) begin
      noise();
      observe("fault", S_FAULT);
    end
    do_reset();
  endtask
  initial begin
    bus.op = 4'd0;
    bus.cz = 2'd0;
    noise();
    #2;
    do_reset();
    run_instr(OP_LW, 2'b00, 0, 0);
    run_instr(OP_ADD, 2'b00, 3, 0);
    run_instr(OP_SW, 2'b00, LIMIT - 1, LIMIT - 1);
    run_instr(OP_LW, 2'b00, 1, LIMIT - 1);
    timeout_test(OP_LW, S_MRD);
    timeout_test(OP_SW, S_MWR);
    timeout_test(OP_ADD, S_FETCH);
    bus.op = OP_LW;
    mem_phase("fetch_pre_reset", S_FETCH, 2, 1'b0);
    do_reset();
    for (int n = 0; n < 300; n++)
      run_instr(ops[$urandom_range(0, 15)], 2'($urandom),
                ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(0, LIMIT - 1)),
                ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(0, LIMIT - 1)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised second-generation multicycle control unit for the 16-bit NITC-RISC24 core; drives the existing datapath's muxes, register file, ALU and memory enables.
- Adds several features over the first-generation controller:
  - a variable-latency memory handshake with timeout fault;
  - carry/zero condition flags with cz-conditional execution;
  - ADI, JAL and HALT;
  - a retired-instruction counter.

Parameters:
- OP_W, 4, opcode width (instr[15:12]).
- WAIT_W, 4, memory wait counter width; timeout after 2^WAIT_W-1 consecutive not-ready cycles.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  OP_W  opcode from IR
- cz  in  2  condition field, instr[1:0]
- alu_zero  in  1  combinational ALU result == 0
- alu_carry  in  1  combinational ALU carry-out
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (valid with mem_req)
- iord  out  1  0=PC address, 1=ALUOut address
- ir_write  out  1  load IR
- pc_write  out  1  load PC (conditional term already merged)
- pc_src  out  1  0=ALU result, 1=ALUOut
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=+1, 10=sext imm6, 11=sext imm6 (branch offset)
- alu_op  out  2  00=ADD, 01=SUB, 10=NAND
- alu_cin  out  1  carry-in to adder
- reg_write  out  1  register file write
- reg_dst  out  2  00=instr[8:6], 01=instr[5:3], 10=instr[11:9]
- wb_sel  out  2  00=ALUOut, 01=MDR, 10=PC
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- state_o  out  4  current state
- halted  out  1  in HALT
- fault  out  1  in FAULT
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset and default outputs:
  - Reset (async): state=START, flag_c=flag_z=0, retired=0, wait counter=0.
  - Every output not listed for a state is 0.
  - In START all outputs are 0. START->FETCH unconditionally.
- Memory states (FETCH, MRD, MWR):
  - mem_req=1; state holds while mem_ready=0.
  - Wait counter increments each not-ready cycle and clears on leaving the state.
  - Counter reaching 2^WAIT_W-1 with mem_ready still 0 -> FAULT.
  - mem_ready=1 on the same cycle as the limit -> normal completion (ready wins).
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD. ir_write and pc_write are asserted only in the mem_ready cycle (Mealy). Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch/jump target into ALUOut). Next state by op:
  - 0000 ADD, 0010 NDU:
    - cz=10 with flag_c=0, or cz=01 with flag_z=0 -> FETCH (skipped, not retired).
    - otherwise -> EXEC.
  - 0001 ADI -> EXEC.
  - 1010 LW, 1001 SW -> MADR.
  - 1011 BEQ -> BEQ.
  - 1101 JAL -> JAL.
  - 1111 -> HALT.
  - others -> FETCH (NOP, not retired).
- EXEC: alu_src_a=1; alu_src_b=10 for ADI, else 00.
  - alu_op=ADD for ADD/ADI, NAND for NDU.
  - alu_cin=flag_c when op=ADD and cz=11.
  - Flags sampled at the clock edge ending EXEC: ADD/ADI update C and Z; NDU updates Z only.
  - Next state: RWB.
- RWB: reg_write=1, wb_sel=00, reg_dst=00 for ADI, 01 for ADD/NDU. Next state: FETCH.
- MADR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state: MRD for LW, MWR for SW.
- MRD: iord=1; on mem_ready -> MWB.
- MWB: reg_write=1, wb_sel=01, reg_dst=00. Next state: FETCH.
- MWR: iord=1, mem_we=1; on mem_ready -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=1, pc_write=alu_zero. Next state: FETCH.
- JAL: reg_write=1, wb_sel=10, reg_dst=10, pc_write=1, pc_src=1. Next state: FETCH.
- HALT, FAULT: terminal until reset. halted=1 or fault=1 respectively; all other outputs 0.
- Retired counter:
  - Increments (wrapping) on each transition into FETCH from RWB, MWB, MWR, BEQ or JAL.
  - Holds on skip, NOP, START, HALT and FAULT.
- Reset asserted mid-instruction: immediate return to START, flags and counter cleared, in-flight access abandoned (mem_req drops asynchronously).

Decomposition:
- Package mc_pkg holds:
  - state encoding constants: START, FETCH, DECODE, EXEC, RWB, MADR, MRD, MWB, MWR, BEQ, JAL, HALT, FAULT;
  - opcode constants;
  - alu_op, alu_src_b, reg_dst and wb_sel encodings.
- One sub-module, mc_mem_wait: wait counter plus timeout compare, parametrised by WAIT_W. Inputs: in_mem_state, mem_ready. Output: timeout.

Test Plan:
- Reset, then mem_ready=1 always, LW (op=1010) -> states START,FETCH,DECODE,MADR,MRD,MWB,FETCH. reg_write=1 with wb_sel=01 in MWB; retired=1.
- FETCH with mem_ready low 3 cycles, WAIT_W=4 -> state holds FETCH 4 cycles; ir_write/pc_write pulse only in cycle 4; no fault.
- mem_ready held low in MRD, WAIT_W=2 -> FAULT after 3 not-ready cycles; fault=1, mem_req=0. Asserting reset returns to START.
- ADD with alu_carry=1, alu_zero=0 -> flag_c=1. Then ADD cz=01 (flag_z=0) -> DECODE->FETCH, retired unchanged. Then ADD cz=11 -> alu_cin=1 in EXEC.
- BEQ with alu_zero=1 -> pc_write=1, pc_src=1; with alu_zero=0 -> pc_write=0. Both retire.
- CNT_W=2, five retired SW instructions -> retired sequence 1,2,3,0,1. Then op=1111 -> halted=1 and the counter frozen.
